// File: rtl/pot_scan_pkg.sv
// Shared types and width helpers for the pot scanning controller.
package pot_scan_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, UPDATE} state_t;

  // Counter widths derived from the instance parameters.
  function automatic int to_w(input int timeout_cyc);
    return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
  endfunction

  function automatic int set_w(input int settle_samples);
    return $clog2(settle_samples + 1);
  endfunction

endpackage

// File: rtl/pot_smooth.sv
// One IIR smoothing step: y + ((res - y) >>> shift), or a raw load when unprimed.
module pot_smooth #(
  parameter int RES_W = 12,
  parameter int SH_W  = 4
) (
  input  logic [RES_W-1:0] y_i,
  input  logic [RES_W-1:0] res_i,
  input  logic             primed_i,
  input  logic [SH_W-1:0]  shift_i,
  output logic [RES_W-1:0] y_next_o
);

  logic signed [RES_W:0] diff;
  logic signed [RES_W:0] step;

  // Result always lies between y and res, so the wrap-around truncation is exact.
  always_comb begin
    diff     = $signed({1'b0, res_i}) - $signed({1'b0, y_i});
    step     = diff >>> shift_i;
    y_next_o = primed_i ? RES_W'({1'b0, y_i} + step) : res_i;
  end

endmodule

// File: rtl/pot_scan_ctrl.sv
// Round-robin A2D pot scanner with per-channel IIR smoothing, conversion
// watchdog and a settle-delayed, sticky amplifier enable.
module pot_scan_ctrl
  import pot_scan_pkg::*;
#(
  parameter int NUM_CH         = 6,
  parameter int CH_W           = 3,
  parameter int RES_W          = 12,
  parameter int AVG_SHIFT      = 2,
  parameter int TIMEOUT_CYC    = 4096,
  parameter int SETTLE_SAMPLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    scan_en_i,
  output logic                    strt_cnv_o,
  output logic [CH_W-1:0]         chnnl_o,
  input  logic                    cnv_cmplt_i,
  input  logic [RES_W-1:0]        res_i,
  output logic [NUM_CH*RES_W-1:0] pot_vals_o,
  output logic [NUM_CH-1:0]       pot_upd_o,
  output logic                    all_valid_o,
  input  logic                    valid_i,
  output logic                    amp_on_o,
  output logic                    err_timeout_o
);

  localparam int TO_W = to_w(TIMEOUT_CYC);
  localparam int SET_W = set_w(SETTLE_SAMPLES);
  localparam int SH_W = $clog2(RES_W + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [SET_W-1:0] SET_DONE = SET_W'(SETTLE_SAMPLES);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t                        state_q, state_d;
  logic [CH_W-1:0]               idx_q, idx_d;
  logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
  logic [RES_W-1:0]              res_q;
  logic                          strt_q;
  logic [NUM_CH-1:0][RES_W-1:0]  vals_q;
  logic [NUM_CH-1:0]             upd_q;
  logic [NUM_CH-1:0]             primed_q;
  logic                          all_valid_q;
  logic                          err_q;
  logic                          valid_prev_q;
  logic [SET_W-1:0]              set_cnt_q;
  logic                          amp_q;
  logic                          cap;
  logic                          to_exp;
  logic [RES_W-1:0]              y_next;

  pot_smooth #(.RES_W(RES_W), .SH_W(SH_W)) u_smooth (
    .y_i      (vals_q[idx_q]),
    .res_i    (res_q),
    .primed_i (primed_q[idx_q]),
    .shift_i  (SH_W'(AVG_SHIFT)),
    .y_next_o (y_next)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    cap      = 1'b0;
    to_exp   = 1'b0;
    unique case (state_q)
      IDLE:  if (scan_en_i) state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        // A completion on the expiry cycle still counts as a good conversion.
        if (cnv_cmplt_i) begin
          cap      = 1'b1;
          to_cnt_d = '0;
          state_d  = UPDATE;
        end else if (to_cnt_q == TO_LAST) begin
          to_exp   = 1'b1;
          to_cnt_d = '0;
          state_d  = START;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      UPDATE: begin
        idx_d   = (idx_q == CH_LAST) ? '0 : idx_q + 1'b1;
        state_d = scan_en_i ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      res_q        <= '0;
      strt_q       <= 1'b0;
      vals_q       <= '0;
      upd_q        <= '0;
      primed_q     <= '0;
      all_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      valid_prev_q <= 1'b0;
      set_cnt_q    <= '0;
      amp_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      strt_q   <= (state_d == START);
      if (cap) res_q <= res_i;
      upd_q <= '0;
      if (state_q == UPDATE) begin
        vals_q[idx_q]   <= y_next;
        upd_q[idx_q]    <= 1'b1;
        primed_q[idx_q] <= 1'b1;
      end
      all_valid_q  <= &primed_q;
      if (to_exp) err_q <= 1'b1;
      valid_prev_q <= valid_i;
      // Counter freezes at the target; amp_on follows one edge later and sticks.
      if (set_cnt_q == SET_DONE) amp_q <= 1'b1;
      else if (all_valid_q && valid_i && !valid_prev_q) set_cnt_q <= set_cnt_q + 1'b1;
    end
  end

  assign strt_cnv_o    = strt_q;
  assign chnnl_o       = idx_q;
  assign pot_vals_o    = vals_q;
  assign pot_upd_o     = upd_q;
  assign all_valid_o   = all_valid_q;
  assign amp_on_o      = amp_q;
  assign err_timeout_o = err_q;

endmodule

// File: doc/pot_scan_ctrl.md
Name: pot_scan_ctrl

Overview:
- Parametrised, N-channel successor to the fixed 6-pot slide interface and the unimplemented AMP_ON delay logic in the equalizer top level.
- Round-robins the A2D interface over NUM_CH channels and IIR-smooths each pot reading into its own register.
- Detects A2D stalls with a watchdog.
- Asserts amp_on only after every channel holds a valid value and the CODEC has delivered SETTLE_SAMPLES sample strobes.
- Sits between A2D_intf and the equalizer core.

Parameters:
- NUM_CH, 6: number of pot channels scanned; A2D channel index = scan index, 0..NUM_CH-1.
- CH_W, 3: width of chnnl; must satisfy NUM_CH <= 2**CH_W.
- RES_W, 12: A2D result width.
- AVG_SHIFT, 2: IIR smoothing shift; 0 = bypass, so the value is the raw result.
- TIMEOUT_CYC, 4096: clk cycles in WAIT before a conversion is abandoned.
- SETTLE_SAMPLES, 1024: CODEC valid rising edges counted after all_valid before amp_on.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- scan_en, in, 1: level; enables scanning.
- strt_cnv, out, 1: one-cycle start pulse to A2D.
- chnnl, out, CH_W: channel being converted.
- cnv_cmplt, in, 1: A2D conversion-complete strobe.
- res, in, RES_W: A2D result, valid while cnv_cmplt=1.
- pot_vals, out, NUM_CH*RES_W: smoothed values, channel i at bits [i*RES_W +: RES_W].
- pot_upd, out, NUM_CH: one-cycle pulse per channel update.
- all_valid, out, 1: every channel has been loaded at least once since reset.
- valid, in, 1: CODEC sample strobe (level; rising edges counted).
- amp_on, out, 1: amplifier enable, sticky.
- err_timeout, out, 1: sticky, set on any watchdog expiry.

Behaviour:
- Reset (async, rst=1): state IDLE; idx=0; chnnl=0; strt_cnv=0; pot_vals=0; pot_upd=0; primed bits=0; all_valid=0; amp_on=0; err_timeout=0; timeout and settle counters=0. All outputs are registered.
- FSM states: IDLE, START, WAIT, UPDATE.
- IDLE: with scan_en=1, go to START on the next edge.
- START: strt_cnv=1 for exactly this cycle; chnnl=idx, held stable from START through UPDATE. Go to WAIT.
- WAIT: timeout counter increments each cycle.
  - cnv_cmplt=1: capture res, clear the counter, go to UPDATE.
  - Counter reaches TIMEOUT_CYC-1 without cnv_cmplt: set err_timeout, clear the counter, go to START with the same idx.
  - cnv_cmplt on the expiry cycle: cnv_cmplt wins.
- UPDATE:
  - Write the filtered value to channel idx; set primed[idx].
  - pot_vals and pot_upd[idx] become visible the cycle after UPDATE; pot_upd[idx] is high for that one cycle.
  - idx wraps NUM_CH-1 -> 0.
  - Next state is START if scan_en=1, else IDLE.
- scan_en deassert mid-conversion: the current channel completes through UPDATE, then the FSM parks in IDLE. Resume continues from the next idx.
- Filter, first load (primed[idx]=0): y <= res.
- Filter, subsequent loads: diff = signed(RES_W+1) (res - y); y <= y + (diff >>> AVG_SHIFT). The arithmetic shift floors toward -infinity. The result always lies between the old y and res, so no saturation is needed.
- all_valid = AND of primed bits, registered.
- Settle counter:
  - Counts rising edges of valid only while all_valid=1; valid is edge-detected internally, with the previous-sample register reset to 0.
  - Rising edge of valid that takes the count to SETTLE_SAMPLES: amp_on=1 on the following edge.
  - After amp_on is set, the counter freezes; amp_on stays 1 until rst.
  - amp_on is unaffected by scan_en or err_timeout.
- Throughput: one channel per (A2D latency + 3) cycles.

Decomposition:
- Shared package pot_scan_pkg:
  - state_t enum {IDLE, START, WAIT, UPDATE}.
  - Localparams TO_W = $clog2(TIMEOUT_CYC) and SET_W = $clog2(SETTLE_SAMPLES+1).
- One natural sub-module, pot_smooth: combinational filter step with inputs y, res, primed, shift and output y_next.
  - Instanced once; the per-channel registers are muxed by idx.

Test Plan:
- Scan order (NUM_CH=6, A2D model with 20-cycle latency, scan_en=1):
  - chnnl sequence is 0,1,2,3,4,5,0.
  - strt_cnv pulses exactly 1 cycle each.
  - pot_upd one-hot pulses follow the same order.
- Filter (AVG_SHIFT=2):
  - First result 0x100 loads 0x100 directly, and all_valid rises after channel 5.
  - Then res 0x200 gives 0x140; res 0x100 from 0x200 gives 0x1C0; res 0x0FF from 0x100 gives 0x0FF.
- Timeout (TIMEOUT_CYC=16, A2D model drops cnv_cmplt once on channel 3):
  - err_timeout set after 16 WAIT cycles.
  - strt_cnv is reissued with chnnl=3.
  - The scan then continues normally.
- Amp-on (SETTLE_SAMPLES=4):
  - valid toggles before all_valid: amp_on stays 0.
  - After all_valid, amp_on rises the edge after the 4th valid rising edge.
  - amp_on stays 1 when scan_en=0.
- Pause (deassert scan_en during WAIT on channel 2):
  - Channel 2 still updates, then the FSM idles with no strt_cnv.
  - On reassert, the next chnnl is 3.
- Reset mid-operation (assert rst during WAIT with amp_on=1):
  - All outputs return to reset values immediately (asynchronously).
  - After release, the first result per channel loads unfiltered.
